mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, number of lost arbitrations before a low-priority requester overrides VGA.
REQ-004 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on rising edge
  reset  in  1  asynchronous, active-low reset
  vga_req  in  1  VGA read request
  vga_addr  in  ADDR_WIDTH  VGA read address
  vga_gnt  out  1  VGA request accepted (1-cycle pulse)
  vga_rvalid  out  1  rdata holds the VGA read result (1-cycle pulse)
  snes_req  in  1  SNES button-store write request
  snes_addr  in  ADDR_WIDTH  SNES write address
  snes_wdata  in  DATA_WIDTH  SNES write data
  snes_gnt  out  1  SNES write accepted and performed (1-cycle pulse)
  cpu_req  in  1  CPU/DMA request
  cpu_we  in  1  1 = write, 0 = read
  cpu_addr  in  ADDR_WIDTH  CPU address
  cpu_wdata  in  DATA_WIDTH  CPU write data
  cpu_gnt  out  1  CPU request accepted (1-cycle pulse)
  cpu_rvalid  out  1  rdata holds the CPU read result (1-cycle pulse)
  rdata  out  DATA_WIDTH  registered read data, shared by all readers
  mem_we  out  1  memory port B write enable
  mem_addr  out  ADDR_WIDTH  memory port B address
  mem_wdata  out  DATA_WIDTH  memory port B write data
  mem_rdata  in  DATA_WIDTH  memory port B read data (1-cycle synchronous read)
  busy  out  1  high whenever state is not IDLE

Function
REQ-005 SHALL implement three states: IDLE, ISSUE, WAIT.
REQ-006 In IDLE with any req high at cycle T, SHALL select a winner and register its address, write data and direction at the end of T; next state ISSUE.
REQ-007 In ISSUE (T+1), SHALL drive mem_addr and mem_wdata from the registered values, assert mem_we only for a write, and pulse the winner's gnt.
REQ-008 After ISSUE, a write SHALL return to IDLE at T+2; a read SHALL enter WAIT at T+2.
REQ-009 In WAIT, SHALL load mem_rdata into rdata at the end of the cycle, return to IDLE, and pulse the winner's rvalid at T+3.
REQ-010 rdata SHALL hold its value until the next WAIT capture.
REQ-011 mem_we SHALL be 0 in every state except ISSUE; mem_addr and mem_wdata SHALL hold their last values outside ISSUE.
REQ-012 Priority SHALL be VGA first, then SNES and CPU in round-robin order, with a last-grant pointer toggled on each SNES or CPU grant.
REQ-013 Each of SNES and CPU SHALL have a saturating 4-bit wait counter, incremented in IDLE when its req is high and it loses, and cleared on its grant or when its req is low.
REQ-014 A counter that is at least STARVE_LIMIT SHALL make its requester win over VGA; if both counters qualify, round-robin order decides.
REQ-015 Requests SHALL be sampled only in IDLE; requesters hold req, addr and data until gnt; a req still high after gnt is a new request.
REQ-016 At most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-017 Address and data SHALL pass through unmodified, with no arithmetic and no address wrap.

Reset
REQ-018 On reset low, SHALL asynchronously enter IDLE and clear every output, rdata, both wait counters and the pointer (next round-robin winner is SNES).
REQ-019 Reset during ISSUE or WAIT SHALL abort the transaction, with no gnt, rvalid or mem_we afterwards; a write aborted in ISSUE is not guaranteed to complete.
REQ-020 After reset is released, the first arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-021 CPU read of addr 0x0010, mem holds 0xBEEF: req at T -> cpu_gnt at T+1, cpu_rvalid at T+3, rdata = 0xBEEF.
REQ-022 SNES write 0x0A5F to 0x00F0: snes_gnt and mem_we both high at T+1 only, mem_addr = 0x00F0; busy low at T+2.
REQ-023 vga_req, snes_req and cpu_req all high from reset: VGA wins at T+1; SNES and CPU counters increment on each loss.
REQ-024 vga_req held high continuously with cpu_req high: CPU is granted after losing 8 arbitrations, then VGA resumes.
REQ-025 SNES and CPU requesting continuously with VGA idle: grants alternate SNES, CPU, SNES, ...
REQ-026 Reset pulled low in WAIT of a CPU read: no cpu_rvalid, rdata = 0, state IDLE, mem_we = 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for memory port B: VGA reads have priority, SNES writes and CPU
// accesses share round-robin, and a starvation counter lets either one override VGA.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    input  logic                  snes_req,
    input  logic [ADDR_WIDTH-1:0] snes_addr,
    input  logic [DATA_WIDTH-1:0] snes_wdata,
    output logic                  snes_gnt,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {W_VGA, W_SNES, W_CPU} who_t;

    state_t     state;
    who_t       owner;
    who_t       sel;
    logic       sel_valid;
    logic       rr_cpu;
    logic [3:0] snes_cnt;
    logic [3:0] cpu_cnt;
    logic       snes_hot;
    logic       cpu_hot;

    assign busy = (state != IDLE);

    always_comb begin
        snes_hot  = snes_req && (int'(snes_cnt) >= STARVE_LIMIT);
        cpu_hot   = cpu_req && (int'(cpu_cnt) >= STARVE_LIMIT);
        sel_valid = vga_req || snes_req || cpu_req;
        sel       = W_VGA;
        if (snes_hot && cpu_hot)       sel = rr_cpu ? W_CPU : W_SNES;
        else if (snes_hot)             sel = W_SNES;
        else if (cpu_hot)              sel = W_CPU;
        else if (vga_req)              sel = W_VGA;
        else if (snes_req && cpu_req)  sel = rr_cpu ? W_CPU : W_SNES;
        else if (snes_req)             sel = W_SNES;
        else if (cpu_req)              sel = W_CPU;
    end

    // Grant, address, data and write enable are registered on the arbitration edge so
    // they are valid for exactly the ISSUE cycle; mem_we also records the direction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= W_VGA;
            rr_cpu     <= 1'b0;
            snes_cnt   <= '0;
            cpu_cnt    <= '0;
            vga_gnt    <= 1'b0;
            snes_gnt   <= 1'b0;
            cpu_gnt    <= 1'b0;
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            rdata      <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            vga_gnt    <= 1'b0;
            snes_gnt   <= 1'b0;
            cpu_gnt    <= 1'b0;
            vga_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!snes_req || sel == W_SNES) snes_cnt <= '0;
                    else if (snes_cnt != '1)         snes_cnt <= snes_cnt + 4'd1;
                    if (!cpu_req || sel == W_CPU)   cpu_cnt <= '0;
                    else if (cpu_cnt != '1)          cpu_cnt <= cpu_cnt + 4'd1;
                    if (sel_valid) begin
                        owner <= sel;
                        state <= ISSUE;
                        case (sel)
                            W_SNES: begin
                                snes_gnt  <= 1'b1;
                                mem_addr  <= snes_addr;
                                mem_wdata <= snes_wdata;
                                mem_we    <= 1'b1;
                                rr_cpu    <= ~rr_cpu;
                            end
                            W_CPU: begin
                                cpu_gnt   <= 1'b1;
                                mem_addr  <= cpu_addr;
                                mem_wdata <= cpu_wdata;
                                mem_we    <= cpu_we;
                                rr_cpu    <= ~rr_cpu;
                            end
                            default: begin
                                vga_gnt   <= 1'b1;
                                mem_addr  <= vga_addr;
                            end
                        endcase
                    end
                end
                ISSUE: state <= mem_we ? IDLE : WAIT;
                WAIT: begin
                    rdata <= mem_rdata;
                    state <= IDLE;
                    case (owner)
                        W_VGA:   vga_rvalid <= 1'b1;
                        W_CPU:   cpu_rvalid <= 1'b1;
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
